// File: rtl/plate_horizontal_projection.sv
// Row projection of a binarised stream: per-row set-bit counts, active-row run tracking,
// and per-frame top/bottom row latch. `HPROJ_RUN_FILTER_EN` requires MIN_RUN_ROWS-long runs.
module plate_horizontal_projection #(
    parameter logic [9:0] IMG_HDISP    = 10'd640,
    parameter logic [9:0] IMG_VDISP    = 10'd480,
    parameter logic [9:0] ROW_THRESH   = 10'd30,
    parameter logic [3:0] MIN_RUN_ROWS = 4'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_Bit,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit,
    output logic [9:0] max_line_up,
    output logic [9:0] max_line_down,
    output logic       proj_found,
    output logic       proj_valid
);

`ifdef HPROJ_RUN_FILTER_EN
    localparam logic [3:0] MIN_RUN = (MIN_RUN_ROWS == 4'd0) ? 4'd1 : MIN_RUN_ROWS;
`else
    // Without the filter every single active row already qualifies.
    localparam logic [3:0] MIN_RUN = 4'd1 | (MIN_RUN_ROWS & 4'd0);
`endif
    localparam logic [9:0] H_LAST = IMG_HDISP - 10'd1;

    typedef enum logic {IDLE, IN_RUN} state_t;

    logic [1:0] vsync_q, href_q, clken_q, bit_q;
    logic [9:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [9:0] row_sum_q, row_sum_d, row_sum_r_q, row_sum_r_d, row_y_q, row_y_d;
    logic       row_done_q, row_done_d;
    state_t     state_q, state_d;
    logic [3:0] run_len_q, run_len_d;
    logic [9:0] run_start_q, run_start_d, top_q, top_d, bottom_q, bottom_d;
    logic       found_q, found_d;
    logic [2:0] neg_dly_q;
    logic [9:0] up_q, down_q;
    logic       proj_found_q, proj_valid_q;

    logic       vsync_pos, vsync_neg;
    logic [9:0] x_base, y_base, sum_base, sum_inc, run_first;
    logic [3:0] len_now;
    logic       row_active, row_in_range;

    assign vsync_pos = per_frame_vsync & ~vsync_q[0];
    assign vsync_neg = ~per_frame_vsync & vsync_q[0];

    // A pixel arriving with the rising vsync belongs to the new frame at (0,0).
    assign x_base   = vsync_pos ? 10'd0 : x_cnt_q;
    assign y_base   = vsync_pos ? 10'd0 : y_cnt_q;
    assign sum_base = vsync_pos ? 10'd0 : row_sum_q;
    assign sum_inc  = (sum_base == 10'h3FF) ? sum_base : sum_base + {9'd0, per_img_Bit};

    always_comb begin
        x_cnt_d     = x_base;
        y_cnt_d     = y_base;
        row_sum_d   = sum_base;
        row_sum_r_d = row_sum_r_q;
        row_y_d     = row_y_q;
        row_done_d  = 1'b0;
        if (per_frame_clken) begin
            if (x_base == H_LAST) begin
                x_cnt_d     = 10'd0;
                y_cnt_d     = (y_base == 10'h3FF) ? y_base : y_base + 10'd1;
                row_sum_d   = 10'd0;
                row_sum_r_d = sum_inc;
                row_y_d     = y_base;
                row_done_d  = 1'b1;
            end else begin
                x_cnt_d   = x_base + 10'd1;
                row_sum_d = sum_inc;
            end
        end
    end

    assign row_active   = row_sum_r_q > ROW_THRESH;
    assign row_in_range = row_y_q < IMG_VDISP;
    assign run_first    = (state_q == IDLE) ? row_y_q : run_start_q;
    assign len_now      = (state_q == IDLE) ? 4'd1 :
                          ((run_len_q == 4'hF) ? run_len_q : run_len_q + 4'd1);

    // Bottom follows every qualifying active row, so a run that is still open at the
    // last row or at a truncated frame end already holds its last completed row.
    always_comb begin
        state_d     = state_q;
        run_len_d   = run_len_q;
        run_start_d = run_start_q;
        top_d       = top_q;
        bottom_d    = bottom_q;
        found_d     = found_q;
        if (vsync_pos) begin
            state_d     = IDLE;
            run_len_d   = 4'd0;
            run_start_d = 10'd0;
            top_d       = 10'd0;
            bottom_d    = 10'd0;
            found_d     = 1'b0;
        end else if (row_done_q && row_in_range) begin
            if (row_active) begin
                state_d     = IN_RUN;
                run_start_d = run_first;
                run_len_d   = len_now;
                if (len_now >= MIN_RUN) begin
                    if (!found_q) begin
                        top_d   = run_first;
                        found_d = 1'b1;
                    end
                    bottom_d = row_y_q;
                end
            end else begin
                state_d   = IDLE;
                run_len_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 2'b00;
            href_q       <= 2'b00;
            clken_q      <= 2'b00;
            bit_q        <= 2'b00;
            x_cnt_q      <= 10'd0;
            y_cnt_q      <= 10'd0;
            row_sum_q    <= 10'd0;
            row_sum_r_q  <= 10'd0;
            row_y_q      <= 10'd0;
            row_done_q   <= 1'b0;
            state_q      <= IDLE;
            run_len_q    <= 4'd0;
            run_start_q  <= 10'd0;
            top_q        <= 10'd0;
            bottom_q     <= 10'd0;
            found_q      <= 1'b0;
            neg_dly_q    <= 3'b000;
            up_q         <= 10'd0;
            down_q       <= 10'd0;
            proj_found_q <= 1'b0;
            proj_valid_q <= 1'b0;
        end else begin
            vsync_q      <= {vsync_q[0], per_frame_vsync};
            href_q       <= {href_q[0], per_frame_href};
            clken_q      <= {clken_q[0], per_frame_clken};
            bit_q        <= {bit_q[0], per_img_Bit};
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            row_sum_q    <= row_sum_d;
            row_sum_r_q  <= row_sum_r_d;
            row_y_q      <= row_y_d;
            row_done_q   <= row_done_d;
            state_q      <= state_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            top_q        <= top_d;
            bottom_q     <= bottom_d;
            found_q      <= found_d;
            // Three-cycle delay lets the final row's classification settle before latching.
            neg_dly_q    <= {neg_dly_q[1:0], vsync_neg};
            proj_valid_q <= neg_dly_q[2];
            if (neg_dly_q[2]) begin
                up_q         <= found_q ? top_q : 10'd0;
                down_q       <= found_q ? bottom_q : 10'd0;
                proj_found_q <= found_q;
            end
        end
    end

    assign post_frame_vsync = vsync_q[1];
    assign post_frame_href  = href_q[1];
    assign post_frame_clken = clken_q[1];
    assign post_img_Bit     = bit_q[1];
    assign max_line_up      = up_q;
    assign max_line_down    = down_q;
    assign proj_found       = proj_found_q;
    assign proj_valid       = proj_valid_q;

endmodule
